wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and integer register file for the RV32I five-stage pipeline. It consumes the MEM/WB pipeline outputs, extracts and extends load data, selects the writeback value, and commits it into a 32×32 register file. Two combinational read ports serve the decode stage. A retired-instruction counter supports performance measurement.

## Interface
- XLEN, 32, data width; fixed at 32 for RV32I
- clk  in  1  clock; all state updates on posedge (MEM/WB pipeline updates on negedge)
- reset  in  1  synchronous, active-high
- wb_read_data  in  32  aligned memory word from MEM/WB
- wb_alu_result  in  32  ALU result / load effective address from MEM/WB
- wb_pc  in  32  PC of the instruction in writeback
- wb_mem_to_reg  in  2  writeback source select
- wb_instruction  in  32  full instruction word in writeback
- wb_reg_write  in  1  register write request
- rs1_addr  in  5  read port 1 address
- rs2_addr  in  5  read port 2 address
- rs1_data  out  32  read port 1 data, combinational
- rs2_data  out  32  read port 2 data, combinational
- wb_write_en  out  1  effective write enable, combinational; exported for EX forwarding
- wb_rd_addr  out  5  wb_instruction[11:7]
- wb_write_data  out  32  selected writeback value, combinational
- instret  out  64  retired-instruction count

## Operation
- Source select on wb_mem_to_reg: 00 → wb_alu_result; 01 → load data; 10 → wb_pc + 4, modulo 2^32; 11 → wb_alu_result.
- Load extraction uses funct3 = wb_instruction[14:12] and offset = wb_alu_result[1:0]:
  - LB (000): sign-extend the byte at `offset`.
  - LBU (100): zero-extend the byte at `offset`.
  - LH (001): sign-extend `word[31:16]` if `offset[1]` is 1, else `word[15:0]`. `offset[0]` is ignored.
  - LHU (101): same as LH but zero-extended.
  - LW (010) and all other funct3 values: the full word.
- wb_write_en = wb_reg_write AND (wb_rd_addr ≠ 0). x0 is never written and always reads 0.
- On posedge with wb_write_en = 1, regs[wb_rd_addr] ← wb_write_data.
- Reads: rsN_data = 0 if rsN_addr = 0, else regs[rsN_addr], subject to the bypass described under Configuration.
- instret increments by 1 on each posedge where wb_instruction ≠ 32'h0000_0000. The all-zero word is the bubble produced by pipeline reset or flush. instret wraps modulo 2^64.

## Timing
- Reset is synchronous: on a posedge with reset = 1, all 31 registers and instret go to 0.
  - No register write occurs on that edge, even if wb_write_en = 1; reset wins.
  - rs1_data = rs2_data = 0 in the cycle after reset.
- Reset outputs follow their inputs combinationally: wb_write_en, wb_rd_addr and wb_write_data track the MEM/WB inputs during reset. With the MEM/WB stage also in reset, they are 0.
- Write latency: the value is committed at the first posedge after it is presented. Without bypass, a read of the same address shows the new value after that edge.
- Same-address writes on consecutive edges: the last write wins; there are no hazards within the block.
- Both read ports may address the same register, or the destination register, simultaneously. Each port resolves independently.
- A read of address 0 during a write with wb_rd_addr = 0 returns 0.

## Configuration
- WB_BYPASS_EN defined: when wb_write_en = 1 and rsN_addr = wb_rd_addr (nonzero), rsN_data = wb_write_data in the same cycle (write-through). Decode sees the value before the posedge commit.
- WB_BYPASS_EN undefined: rsN_data always reflects stored state. The hazard unit must stall or forward for a same-cycle WB/ID dependency.

## Test plan
- Reset with wb_reg_write = 1, rd = 5 → x5 reads 0 after the edge; instret = 0.
- ALU writeback: wb_mem_to_reg = 00, rd = 3, wb_alu_result = 0x1234_5678 → x3 = 0x1234_5678 after the edge. A write to rd = 0 leaves x0 reading 0, and wb_write_en = 0.
- Loads with wb_read_data = 0x80FF_7F01:
  - LB, offset 3 → 0xFFFF_FF80.
  - LBU, offset 3 → 0x0000_0080.
  - LH, offset 2 → 0xFFFF_80FF.
  - LHU, offset 0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- JAL link: wb_mem_to_reg = 10, wb_pc = 0x0000_0100, rd = 1 → x1 = 0x0000_0104. With wb_pc = 0xFFFF_FFFC → x1 = 0.
- Bypass: rd = 7, data 0xDEAD_BEEF, rs1_addr = rs2_addr = 7 in the same cycle.
  - With WB_BYPASS_EN: both ports read 0xDEAD_BEEF before the edge.
  - Without WB_BYPASS_EN: both ports read the old value until the edge.
- instret: 10 cycles of 0x0000_0013 interleaved with 3 cycles of 0x0000_0000 → instret = 10. Asserting reset mid-sequence returns it to 0 on that edge.

Source files
------------

// File: rtl/wb_regfile.sv
// RV32I writeback stage and 32x32 integer register file with a retired-instruction counter.
// Optional same-cycle write-through to the read ports when WB_BYPASS_EN is defined.
module wb_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] wb_read_data,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [1:0]      wb_mem_to_reg,
  input  logic [XLEN-1:0] wb_instruction,
  input  logic            wb_reg_write,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_write_en,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_write_data,
  output logic [63:0]     instret
);

  logic [XLEN-1:0] regs_r [1:31];
  logic [XLEN-1:0] load_data_s;

  // Byte/halfword lane pick and extension; offset[0] is ignored for halfwords.
  function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] word,
                                                   input logic [2:0] funct3,
                                                   input logic [1:0] offset);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    case (offset)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  extract_load = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b100:  extract_load = {{(XLEN-8){1'b0}}, byte_v};
      3'b001:  extract_load = {{(XLEN-16){half_v[15]}}, half_v};
      3'b101:  extract_load = {{(XLEN-16){1'b0}}, half_v};
      default: extract_load = word;
    endcase
  endfunction

  assign wb_rd_addr  = wb_instruction[11:7];
  assign wb_write_en = wb_reg_write && (wb_rd_addr != 5'd0);
  assign load_data_s = extract_load(wb_read_data, wb_instruction[14:12], wb_alu_result[1:0]);

  always_comb begin
    wb_write_data = wb_alu_result;
    case (wb_mem_to_reg)
      2'b00:   wb_write_data = wb_alu_result;
      2'b01:   wb_write_data = load_data_s;
      2'b10:   wb_write_data = wb_pc + 32'd4;
      default: wb_write_data = wb_alu_result;
    endcase
  end

  // Read port 1: x0 is hardwired to zero.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    if (rs1_addr == 5'd0) begin
      rs1_data = {XLEN{1'b0}};
    end else begin
`ifdef WB_BYPASS_EN
      if (wb_write_en && (rs1_addr == wb_rd_addr)) begin
        rs1_data = wb_write_data;
      end else begin
        rs1_data = regs_r[rs1_addr];
      end
`else
      rs1_data = regs_r[rs1_addr];
`endif
    end
  end

  // Read port 2: resolved independently of port 1.
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    if (rs2_addr == 5'd0) begin
      rs2_data = {XLEN{1'b0}};
    end else begin
`ifdef WB_BYPASS_EN
      if (wb_write_en && (rs2_addr == wb_rd_addr)) begin
        rs2_data = wb_write_data;
      end else begin
        rs2_data = regs_r[rs2_addr];
      end
`else
      rs2_data = regs_r[rs2_addr];
`endif
    end
  end

  // Register commit and retire counting; reset overrides any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
      instret <= 64'd0;
    end else begin
      if (wb_write_en) begin
        regs_r[wb_rd_addr] <= wb_write_data;
      end
      if (wb_instruction != 32'h0000_0000) begin
        instret <= instret + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed plan cases plus randomized traffic
// compared against an array-based reference model.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_pc;
  logic [1:0]  wb_mem_to_reg;
  logic [31:0] wb_instruction;
  logic        wb_reg_write;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_write_en;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_write_data;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [63:0] m_instret;

  wb_regfile #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_pc(wb_pc),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_instruction(wb_instruction),
    .wb_reg_write(wb_reg_write), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_write_en(wb_write_en),
    .wb_rd_addr(wb_rd_addr), .wb_write_data(wb_write_data), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load: shift the word down to the addressed lane, mask, then sign-adjust arithmetically.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    longint unsigned w;
    longint v;
    int size;
    int shamt;
    w = longint'(word);
    if (f3 == 3'd0 || f3 == 3'd4) begin
      size = 256;
      shamt = 8 * int'(off);
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      size = 65536;
      shamt = (off >= 2'd2) ? 16 : 0;
    end else begin
      return word;
    end
    v = longint'((w >> shamt) % longint'(size));
    if (f3[2] == 1'b0 && v >= longint'(size / 2)) v = v - longint'(size);
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] mtr, input logic [31:0] instr,
                                            input logic [31:0] alu, input logic [31:0] rdata,
                                            input logic [31:0] pc);
    longint unsigned link;
    link = (longint'(pc) + 4) % 64'h1_0000_0000;
    if (mtr == 2'd1) return ref_load(rdata, instr[14:12], alu[1:0]);
    if (mtr == 2'd2) return 32'(link);
    return alu;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] rd, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (we && a == rd) return wd;
`endif
    return m_regs[a];
  endfunction

  // One MEM/WB cycle: drive on negedge, check combinational outputs, take the posedge, check state.
  task automatic cycle(input logic rst, input logic [1:0] mtr, input logic [31:0] instr,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc,
                       input logic rw, input logic [4:0] a1, input logic [4:0] a2,
                       input logic check_reads);
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    @(negedge clk);
    reset = rst; wb_mem_to_reg = mtr; wb_instruction = instr; wb_alu_result = alu;
    wb_read_data = rdata; wb_pc = pc; wb_reg_write = rw; rs1_addr = a1; rs2_addr = a2;
    #1;
    e_rd = instr[11:7];
    e_we = rw && (e_rd != 5'd0);
    e_wd = ref_wdata(mtr, instr, alu, rdata, pc);
    chk("write_en", 64'(wb_write_en), 64'(e_we));
    chk("rd_addr", 64'(wb_rd_addr), 64'(e_rd));
    chk("write_data", 64'(wb_write_data), 64'(e_wd));
    if (check_reads) begin
      chk("rs1_pre", 64'(rs1_data), 64'(ref_read(a1, e_we, e_rd, e_wd)));
      chk("rs2_pre", 64'(rs2_data), 64'(ref_read(a2, e_we, e_rd, e_wd)));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_instret = 64'd0;
    end else begin
      if (e_we) m_regs[e_rd] = e_wd;
      if (instr != 32'h0) m_instret = m_instret + 64'd1;
    end
    #1;
    chk("instret", instret, m_instret);
    chk("rs1_post", 64'(rs1_data), 64'(ref_read(a1, e_we, e_rd, e_wd)));
    chk("rs2_post", 64'(rs2_data), 64'(ref_read(a2, e_we, e_rd, e_wd)));
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0_0000, f3, rd, 7'b0000011};
  endfunction

  initial begin
    logic [31:0] r_instr;
    logic [4:0]  r_rd;
    logic        r_rst;
    m_instret = 64'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    reset = 1'b1; wb_read_data = 32'h0; wb_alu_result = 32'h0; wb_pc = 32'h0;
    wb_mem_to_reg = 2'b00; wb_instruction = 32'h0; wb_reg_write = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;

    // Reset with a pending write to x5: reset wins.
    cycle(1'b1, 2'b00, mk(3'd0, 5'd5), 32'hAAAA_5555, 32'h0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b0);
    chk("reset_x5", 64'(rs1_data), 64'h0);
    chk("reset_instret", instret, 64'd0);

    // ALU writeback, then an attempt at x0.
    cycle(1'b0, 2'b00, {20'h0, 5'd3, 7'b0110011}, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 1'b1);
    chk("alu_x3", 64'(rs1_data), 64'h1234_5678);
    cycle(1'b0, 2'b00, {20'h0, 5'd0, 7'b0110011}, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b1);
    chk("x0_we", 64'(wb_write_en), 64'd0);
    chk("x0_read", 64'(rs1_data), 64'h0);

    // Load extraction from 0x80FF_7F01.
    cycle(1'b0, 2'b01, mk(3'd0, 5'd10), 32'h0000_1003, 32'h80FF_7F01, 32'h0, 1'b1, 5'd10, 5'd0, 1'b1);
    chk("lb_off3", 64'(rs1_data), 64'hFFFF_FF80);
    cycle(1'b0, 2'b01, mk(3'd4, 5'd11), 32'h0000_1003, 32'h80FF_7F01, 32'h0, 1'b1, 5'd11, 5'd0, 1'b1);
    chk("lbu_off3", 64'(rs1_data), 64'h0000_0080);
    cycle(1'b0, 2'b01, mk(3'd1, 5'd12), 32'h0000_1002, 32'h80FF_7F01, 32'h0, 1'b1, 5'd12, 5'd0, 1'b1);
    chk("lh_off2", 64'(rs1_data), 64'hFFFF_80FF);
    cycle(1'b0, 2'b01, mk(3'd5, 5'd13), 32'h0000_1000, 32'h80FF_7F01, 32'h0, 1'b1, 5'd13, 5'd0, 1'b1);
    chk("lhu_off0", 64'(rs1_data), 64'h0000_7F01);
    cycle(1'b0, 2'b01, mk(3'd2, 5'd14), 32'h0000_1000, 32'h80FF_7F01, 32'h0, 1'b1, 5'd14, 5'd0, 1'b1);
    chk("lw", 64'(rs1_data), 64'h80FF_7F01);

    // JAL link values, including wrap.
    cycle(1'b0, 2'b10, {20'h0, 5'd1, 7'b1101111}, 32'h0, 32'h0, 32'h0000_0100, 1'b1, 5'd1, 5'd0, 1'b1);
    chk("jal_link", 64'(rs1_data), 64'h0000_0104);
    cycle(1'b0, 2'b10, {20'h0, 5'd1, 7'b1101111}, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 5'd1, 5'd0, 1'b1);
    chk("jal_wrap", 64'(rs1_data), 64'h0);

    // Same-cycle read of the destination on both ports.
    cycle(1'b0, 2'b00, {20'h0, 5'd7, 7'b0110011}, 32'h1111_2222, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7, 1'b1);
    @(negedge clk);
    reset = 1'b0; wb_mem_to_reg = 2'b00; wb_instruction = {20'h0, 5'd7, 7'b0110011};
    wb_alu_result = 32'hDEAD_BEEF; wb_reg_write = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_rs1", 64'(rs1_data), 64'hDEAD_BEEF);
    chk("bypass_rs2", 64'(rs2_data), 64'hDEAD_BEEF);
`else
    chk("nobypass_rs1", 64'(rs1_data), 64'h1111_2222);
    chk("nobypass_rs2", 64'(rs2_data), 64'h1111_2222);
`endif
    @(posedge clk);
    m_regs[7] = 32'hDEAD_BEEF;
    m_instret = m_instret + 64'd1;
    #1;
    chk("commit_rs1", 64'(rs1_data), 64'hDEAD_BEEF);
    chk("commit_rs2", 64'(rs2_data), 64'hDEAD_BEEF);
    chk("commit_instret", instret, m_instret);

    // instret: 10 real instructions interleaved with 3 bubbles after a reset.
    cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 13; i++) begin
      if (i == 2 || i == 6 || i == 10)
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd1, 1'b1);
      else
        cycle(1'b0, 2'b00, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd1, 1'b1);
    end
    chk("instret_10", instret, 64'd10);
    cycle(1'b1, 2'b00, 32'h0000_0013, 32'h5, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b1);
    chk("instret_reset", instret, 64'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      r_rd = 5'($urandom_range(0, 31));
      r_instr = {$urandom} & 32'hFFFF_F07F;
      r_instr[11:7] = r_rd;
      if ($urandom_range(0, 7) == 0) r_instr = 32'h0;
      r_rst = ($urandom_range(0, 49) == 0);
      cycle(r_rst, 2'($urandom_range(0, 3)), r_instr, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
